// File: rtl/ddr_cmd_arbiter.sv
// Round-robin arbiter sharing one DDR command slot among NUM_REQ requesters; read returns are routed by an in-order tag FIFO.
// Latency: accept->command 1 cycle, read_data_valid->rsp_valid 1 cycle. Optional grant counters under CMD_ARB_PERF_EN.
// Backpressure: req_ready drops while the slot is held (FULL && !ba_cmd_pm) and reads stall when TAG_DEPTH tags are outstanding.
module ddr_cmd_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int CMD_W     = 32,
   parameter int DATA_W    = 64,
   parameter int TAG_DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      power_on_rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*CMD_W-1:0]  req_command,
   input  logic [NUM_REQ-1:0]        req_is_read,
   input  logic [NUM_REQ*DATA_W-1:0] req_write_data,
   output logic [CMD_W-1:0]          command,
   output logic                      valid,
   output logic [DATA_W-1:0]         write_data,
   input  logic                      ba_cmd_pm,
   input  logic [DATA_W-1:0]         read_data,
   input  logic                      read_data_valid,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err
`ifdef CMD_ARB_PERF_EN
   ,
   output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

   localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TAG_AW = $clog2(TAG_DEPTH);
   localparam int CNT_W  = TAG_AW + 1;

   typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

   slot_state_t          slot_state, slot_state_nxt;
   logic [ID_W-1:0]      rr_ptr;
   logic [ID_W-1:0]      grant_id;
   logic                 grant_found;
   logic                 slot_free;
   logic                 accept;
   logic                 tag_full;
   logic                 tag_push;
   logic                 tag_pop;
   logic [NUM_REQ-1:0]   eligible;
   int                   cand;
   logic [ID_W-1:0]      tag_mem [TAG_DEPTH];
   logic [TAG_AW-1:0]    tag_wr_ptr, tag_rd_ptr;
   logic [CNT_W-1:0]     tag_count;

   assign valid     = (slot_state == SLOT_FULL);
   assign slot_free = !valid || ba_cmd_pm;
   assign tag_full  = (tag_count == CNT_W'(TAG_DEPTH));

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] && (!req_is_read[i] || !tag_full);
      end
   end

   // First eligible requester at or above rr_ptr, wrapping around.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(rr_ptr) + k) % NUM_REQ;
         if (!grant_found && eligible[cand]) begin
            grant_found = 1'b1;
            grant_id    = ID_W'(cand);
         end
      end
   end

   assign accept    = grant_found && slot_free && power_on_rst_n;
   assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;
   assign tag_push  = accept && req_is_read[grant_id];
   assign tag_pop   = read_data_valid && (tag_count != '0);

   always_comb begin
      slot_state_nxt = slot_state;
      if (accept) begin
         slot_state_nxt = SLOT_FULL;
      end else if (valid && ba_cmd_pm) begin
         slot_state_nxt = SLOT_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!power_on_rst_n) begin
         slot_state <= SLOT_EMPTY;
      end else begin
         slot_state <= slot_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!power_on_rst_n) begin
         command    <= '0;
         write_data <= '0;
         rr_ptr     <= '0;
      end else if (accept) begin
         command    <= req_command[grant_id*CMD_W +: CMD_W];
         write_data <= req_write_data[grant_id*DATA_W +: DATA_W];
         rr_ptr     <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_push) begin
         tag_mem[tag_wr_ptr] <= grant_id;
      end
   end

   always_ff @(posedge clk) begin
      if (!power_on_rst_n) begin
         tag_wr_ptr <= '0;
         tag_rd_ptr <= '0;
         tag_count  <= '0;
      end else begin
         if (tag_push) begin
            tag_wr_ptr <= tag_wr_ptr + 1'b1;
         end
         if (tag_pop) begin
            tag_rd_ptr <= tag_rd_ptr + 1'b1;
         end
         case ({tag_push, tag_pop})
            2'b10:   tag_count <= tag_count + 1'b1;
            2'b01:   tag_count <= tag_count - 1'b1;
            default: tag_count <= tag_count;
         endcase
      end
   end

   // A return with nothing outstanding is dropped and flagged until reset.
   always_ff @(posedge clk) begin
      if (!power_on_rst_n) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= tag_pop ? (NUM_REQ'(1) << tag_mem[tag_rd_ptr]) : '0;
         if (tag_pop) begin
            rsp_data <= read_data;
         end
         if (read_data_valid && (tag_count == '0)) begin
            rsp_err <= 1'b1;
         end
      end
   end

`ifdef CMD_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (!power_on_rst_n) begin
         grant_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && (grant_id == ID_W'(i)) && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
               grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Directed bench for ddr_cmd_arbiter: round-robin order, slot hold, tag limit, read return routing, error flag, reset.
module tb_ddr_cmd_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int CMD_W     = 32;
   localparam int DATA_W    = 64;
   localparam int TAG_DEPTH = 8;

   logic                      clk;
   logic                      power_on_rst_n;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*CMD_W-1:0]  req_command;
   logic [NUM_REQ-1:0]        req_is_read;
   logic [NUM_REQ*DATA_W-1:0] req_write_data;
   logic [CMD_W-1:0]          command;
   logic                      valid;
   logic [DATA_W-1:0]         write_data;
   logic                      ba_cmd_pm;
   logic [DATA_W-1:0]         read_data;
   logic                      read_data_valid;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      rsp_err;
`ifdef CMD_ARB_PERF_EN
   logic [NUM_REQ*16-1:0]     grant_cnt;
`endif

   ddr_cmd_arbiter #(
      .NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)
   ) dut (
      .clk            (clk),
      .power_on_rst_n (power_on_rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_command    (req_command),
      .req_is_read    (req_is_read),
      .req_write_data (req_write_data),
      .command        (command),
      .valid          (valid),
      .write_data     (write_data),
      .ba_cmd_pm      (ba_cmd_pm),
      .read_data      (read_data),
      .read_data_valid(read_data_valid),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .rsp_err        (rsp_err)
`ifdef CMD_ARB_PERF_EN
      ,
      .grant_cnt      (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cmd_of(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   function automatic logic [63:0] wd_of(input int i);
      return 64'hDA7A_0000_0000_0000 + 64'(i);
   endfunction

   function automatic logic [3:0] oh(input int i);
      logic [3:0] r;
      r    = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   initial begin
      int id;
      power_on_rst_n  = 1'b0;
      req_valid       = 4'hF;
      req_is_read     = '0;
      ba_cmd_pm       = 1'b0;
      read_data       = '0;
      read_data_valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_command[i*CMD_W +: CMD_W]     = cmd_of(i);
         req_write_data[i*DATA_W +: DATA_W] = wd_of(i);
      end
      @(negedge clk);
      tick();
      tick();

      // Reset state
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_valid", 64'(valid), 64'h0);
      chk("rst_command", 64'(command), 64'h0);
      chk("rst_wdata", write_data, 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_rsp_data", rsp_data, 64'h0);
      chk("rst_rsp_err", 64'(rsp_err), 64'h0);

      // Round robin, all writing, one grant per cycle
      power_on_rst_n = 1'b1;
      ba_cmd_pm      = 1'b1;
      #1;
      chk("rr_ready_first", 64'(req_ready), 64'(oh(0)));
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("rr_valid", 64'(valid), 64'h1);
         chk("rr_command", 64'(command), 64'(cmd_of(k % 4)));
         chk("rr_ready", 64'(req_ready), 64'(oh((k + 1) % 4)));
         if (k == 0) chk("rr_wdata", write_data, wd_of(0));
      end
      req_valid = '0;
      tick();
      chk("rr_drain", 64'(valid), 64'h0);

      // Slot held while the package stalls
      ba_cmd_pm = 1'b0;
      req_valid = 4'b0100;
      #1;
      chk("hold_ready_first", 64'(req_ready), 64'(oh(2)));
      tick();
      req_valid = 4'b0101;
      #1;
      for (int j = 0; j < 5; j++) begin
         chk("hold_valid", 64'(valid), 64'h1);
         chk("hold_command", 64'(command), 64'(cmd_of(2)));
         chk("hold_ready", 64'(req_ready), 64'h0);
         tick();
      end
      chk("hold_wdata", write_data, wd_of(2));
      ba_cmd_pm = 1'b1;
      #1;
      chk("hold_release_ready", 64'(req_ready), 64'(oh(0)));
      tick();
      chk("hold_next_command", 64'(command), 64'(cmd_of(0)));
      req_valid = '0;
      tick();
      chk("hold_drain", 64'(valid), 64'h0);

      // Eight reads from requesters 0 and 3 fill the tag FIFO (rr_ptr=1)
      req_valid   = 4'b1001;
      req_is_read = 4'b1001;
      #1;
      for (int k = 0; k < 8; k++) begin
         id = (k % 2 == 0) ? 3 : 0;
         chk("rd_ready", 64'(req_ready), 64'(oh(id)));
         tick();
         chk("rd_command", 64'(command), 64'(cmd_of(id)));
      end
      chk("rd_ninth_blocked", 64'(req_ready), 64'h0);
      req_valid = 4'b1011;
      #1;
      chk("rd_write_proceeds", 64'(req_ready), 64'(oh(1)));
      tick();
      chk("rd_write_command", 64'(command), 64'(cmd_of(1)));
      req_valid   = '0;
      req_is_read = '0;
      tick();

      // Back-to-back returns in issue order 3,0,3,0,...
      read_data_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         read_data = 64'h100 + 64'(k);
         tick();
         id = (k % 2 == 0) ? 3 : 0;
         chk("ret_rsp_valid", 64'(rsp_valid), 64'(oh(id)));
         chk("ret_rsp_data", rsp_data, 64'h100 + 64'(k));
      end
      read_data_valid = 1'b0;
      tick();
      chk("ret_idle_valid", 64'(rsp_valid), 64'h0);
      chk("ret_data_hold", rsp_data, 64'h107);
      chk("ret_no_err", 64'(rsp_err), 64'h0);

      // Return with nothing outstanding
      read_data       = 64'hDEAD;
      read_data_valid = 1'b1;
      tick();
      read_data_valid = 1'b0;
      chk("err_set", 64'(rsp_err), 64'h1);
      chk("err_no_rsp", 64'(rsp_valid), 64'h0);
      chk("err_data_hold", rsp_data, 64'h107);
      tick();
      chk("err_sticky", 64'(rsp_err), 64'h1);

      // Reset while FULL with 3 tags outstanding (rr_ptr=2 -> requester 1 wins)
      req_valid   = 4'b0010;
      req_is_read = 4'b0010;
      tick();
      tick();
      tick();
      ba_cmd_pm   = 1'b0;
      req_valid   = '0;
      req_is_read = '0;
      tick();
      chk("pre_rst_full", 64'(valid), 64'h1);
      power_on_rst_n = 1'b0;
      req_valid      = 4'b1110;
      #1;
      chk("in_rst_ready", 64'(req_ready), 64'h0);
      tick();
      chk("post_rst_valid", 64'(valid), 64'h0);
      chk("post_rst_command", 64'(command), 64'h0);
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("post_rst_rsp_err", 64'(rsp_err), 64'h0);
      power_on_rst_n = 1'b1;
      ba_cmd_pm      = 1'b1;
      #1;
      chk("post_rst_first_grant", 64'(req_ready), 64'(oh(1)));
      tick();
      chk("post_rst_command1", 64'(command), 64'(cmd_of(1)));
      req_valid       = '0;
      read_data       = 64'h55;
      read_data_valid = 1'b1;
      tick();
      read_data_valid = 1'b0;
      chk("post_rst_tags_empty", 64'(rsp_valid), 64'h0);
      chk("post_rst_err", 64'(rsp_err), 64'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr_cmd_arbiter.md
# ddr_cmd_arbiter

Round-robin arbiter that lets NUM_REQ independent requesters share the single command port of the DDR3 controller package. It presents one command at a time on the package's `command`/`valid`/`write_data` inputs and holds it until the package accepts it via `ba_cmd_pm`. It records the requester ID of every read in an in-order tag FIFO, then routes each `read_data`/`read_data_valid` return back to the requester that issued it.

## Interface

- NUM_REQ, 4, number of requesters (2..8)
- CMD_W, 32, command word width (matches package `command`)
- DATA_W, 64, data width (matches package `write_data`/`read_data`)
- TAG_DEPTH, 8, maximum outstanding reads (power of 2)

- clk  in  1  system clock; single clock domain
- power_on_rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_command  in  NUM_REQ*CMD_W  packed commands; requester i at [i*CMD_W +: CMD_W]
- req_is_read  in  NUM_REQ  1 = command is a read (allocates a tag)
- req_write_data  in  NUM_REQ*DATA_W  packed write data
- command  out  CMD_W  to package
- valid  out  1  to package; command slot occupied
- write_data  out  DATA_W  to package
- ba_cmd_pm  in  1  package ready; a transfer occurs when valid && ba_cmd_pm at a clk edge
- read_data  in  DATA_W  from package
- read_data_valid  in  1  from package
- rsp_valid  out  NUM_REQ  one-hot read-return strobe
- rsp_data  out  DATA_W  returned read data
- rsp_err  out  1  sticky; read_data_valid arrived while no tag was outstanding
- grant_cnt  out  NUM_REQ*16  per-requester grant counters (only with CMD_ARB_PERF_EN)

## Operation

- The output slot is a single register (command, write_data, valid, is_read) with two states:
  - EMPTY (valid=0).
  - FULL (valid=1).
- `slot_free` = EMPTY, or FULL && ba_cmd_pm (the slot is draining this cycle).
- Eligibility: requester i is eligible when req_valid[i]=1, and either req_is_read[i]=0 or tag_count < TAG_DEPTH.
- Arbitration: round-robin among eligible requesters, searching from rr_ptr upward with wrap. The winner g gets req_ready[g]=1 only if slot_free. req_ready is combinational from the inputs and state.
- Acceptance (req_valid[g] && req_ready[g]):
  - The slot loads requester g's command and data; the state is FULL.
  - rr_ptr becomes (g+1) mod NUM_REQ.
  - If the command is a read, g is pushed into the tag FIFO.
- No acceptance while slot_free:
  - If FULL && ba_cmd_pm, the slot goes EMPTY.
  - rr_ptr is unchanged.
- FULL && !ba_cmd_pm: the slot contents are held stable and all req_ready bits are 0.
- Tag FIFO:
  - Depth TAG_DEPTH; count width log2(TAG_DEPTH)+1.
  - Push on read acceptance; pop on read_data_valid when count > 0.
  - Simultaneous push and pop leaves the count unchanged.
  - Eligibility uses the pre-pop count, so a same-cycle pop does not unblock a read.
- Return path:
  - On read_data_valid with count > 0: next cycle, rsp_valid = one-hot(head ID) and rsp_data = read_data.
  - Otherwise rsp_valid = 0 and rsp_data holds its last value.
  - On read_data_valid with count = 0: no pop, rsp_valid stays 0, rsp_err is set to 1 until reset.
- Writes never allocate tags and produce no response.

## Timing

- Reset (power_on_rst_n=0 at a clk edge) clears all of the following, even with a transfer pending; the pending command and outstanding tags are discarded:
  - valid=0, command=0, write_data=0.
  - rr_ptr=0, tag FIFO empty (read/write pointers 0).
  - rsp_valid=0, rsp_data=0, rsp_err=0, grant_cnt=0.
- req_ready is 0 while reset is asserted.
- Request-to-package latency: accepted at edge N, visible on command/valid after edge N (cycle N+1).
- Throughput: with ba_cmd_pm held high, one command per cycle (back-to-back reload of a FULL slot).
- read_data_valid to rsp_valid latency: 1 cycle. Back-to-back returns give back-to-back rsp_valid.
- With all requesters continuously valid and ba_cmd_pm=1, grants are issued in the order 0,1,2,3,0,…
- A requester is granted at most once per NUM_REQ consecutive grants while the others remain eligible.

## Configuration

- CMD_ARB_PERF_EN defined:
  - The grant_cnt port exists.
  - grant_cnt[i*16 +: 16] increments on each acceptance from requester i and saturates at 16'hFFFF.
  - Cleared by reset.
- CMD_ARB_PERF_EN undefined: the grant_cnt port and counters are absent. All other behaviour is identical.

## Test plan

- All 4 requesters issue writes continuously, ba_cmd_pm=1 → grants 0,1,2,3,0,1,… one per cycle; command equals each requester's word one cycle after its req_ready.
- Requester 2 holds a write, ba_cmd_pm=0 for 5 cycles → valid=1 and command stable for 5 cycles, req_ready=0; when ba_cmd_pm rises, one transfer, then the next grant.
- Requesters 0 and 3 issue 8 reads total, read_data_valid is withheld → the 9th read gets req_ready=0 while writes still proceed. Then 8 returns with data 0x100+k → rsp_valid one-hot matches issue order, rsp_data=0x100+k, each 1 cycle after its return.
- read_data_valid pulsed with no outstanding read → rsp_err=1 and stays 1, rsp_valid stays 0.
- Reset asserted while FULL with 3 tags outstanding → next cycle valid=0, rsp_valid=0, tag count 0, rr_ptr=0; the first post-reset grant goes to the lowest eligible requester.
- With CMD_ARB_PERF_EN, 70000 grants to requester 1 → grant_cnt[31:16]=16'hFFFF.
